// File: rtl/led_array_scanner.sv
// LED array column scanner for a Conway-style N x N grid.
// A one-entry shadow buffer accepts new frames through a valid/ready handshake.
// The display register is only updated while idle or at a frame boundary, so the
// LED driver never sees a frame change partway through a scan.
module led_array_scanner #(
  parameter int N            = 5,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [N*N-1:0]     cells_in,
  input  logic               cells_valid,
  output logic               cells_ready,
  output logic               ena,
  output logic [$clog2(N):0] x,
  output logic [N*N-1:0]     cells,
  output logic               frame_done
);

  localparam int XW   = $clog2(N) + 1;
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [XW-1:0] X_LAST     = XW'(N - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N*N-1:0]  shadow_q, shadow_d;
  logic            shadow_full_q, shadow_full_d;
  logic [N*N-1:0]  cells_q, cells_d;
  logic            loaded_q, loaded_d;
  logic            frame_done_q, frame_done_d;
  logic            ena_q, ena_d;
  logic            ready_q, ready_d;
  logic            take;
  logic            promote;
  logic            col_end;

  // Next-state logic: column sequencing, frame-boundary promotion and shadow handshake.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    cnt_d         = cnt_q + CW'(1);
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    cells_d       = cells_q;
    loaded_d      = loaded_q;
    frame_done_d  = 1'b0;
    promote       = 1'b0;
    col_end       = 1'b0;
    take          = cells_valid && ready_q;

    case (state_q)
      IDLE: begin
        x_d     = '0;
        cnt_d   = '0;
        promote = shadow_full_q;
        if (enable && loaded_q) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (cnt_q == DWELL_LAST) begin
          if (BLANK_CYCLES > 0) begin
            state_d = BLANK;
            cnt_d   = '0;
          end else begin
            col_end = 1'b1;
          end
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          col_end = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (col_end) begin
      cnt_d = '0;
      if (x_q == X_LAST) begin
        x_d          = '0;
        frame_done_d = 1'b1;
        promote      = shadow_full_q;
        state_d      = enable ? SCAN : IDLE;
      end else begin
        x_d     = x_q + XW'(1);
        state_d = SCAN;
      end
    end

    if (promote) begin
      cells_d       = shadow_q;
      shadow_full_d = 1'b0;
      loaded_d      = 1'b1;
    end

    if (take) begin
      shadow_d      = cells_in;
      shadow_full_d = 1'b1;
    end

    // Ready stays low for the promotion clock and rises on the one after it.
    ready_d = !shadow_full_d && !promote;
    ena_d   = (state_d == SCAN);
  end

  // State and registered outputs; reset discards both shadow and display contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      x_q           <= '0;
      cnt_q         <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      cells_q       <= '0;
      loaded_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      ena_q         <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      cells_q       <= cells_d;
      loaded_q      <= loaded_d;
      frame_done_q  <= frame_done_d;
      ena_q         <= ena_d;
      ready_q       <= ready_d;
    end
  end

  assign cells_ready = ready_q;
  assign ena         = ena_q;
  assign x           = x_q;
  assign cells       = cells_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_led_array_scanner.sv
// Testbench for led_array_scanner: one instance with blanking, one without.
// A frame-position model predicts every output each cycle; directed steps add
// hand-computed expectations for the key timing points.
module tb_led_array_scanner;

  localparam int DW = 4;
  localparam int BL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        cells_valid = 1'b0;
  logic [24:0] cells_in = '0;
  logic        cells_ready, ena, frame_done;
  logic [2:0]  x;
  logic [24:0] cells;

  logic        en0 = 1'b0;
  logic        valid0 = 1'b0;
  logic [24:0] cin0 = '0;
  logic        ready0, ena0, fd0;
  logic [2:0]  x0;
  logic [24:0] cells0;

  int checks = 0;
  int fails  = 0;
  bit cmp_on = 1'b0;

  typedef struct {
    logic        run;
    int          t;
    logic        sf;
    logic [24:0] sh;
    logic [24:0] cells;
    logic        loaded;
    logic        ready;
    logic        fd;
  } mdl_t;

  mdl_t m, m0;

  led_array_scanner #(.N(5), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cells_in(cells_in),
    .cells_valid(cells_valid), .cells_ready(cells_ready), .ena(ena),
    .x(x), .cells(cells), .frame_done(frame_done)
  );

  led_array_scanner #(.N(5), .DWELL_CYCLES(DW), .BLANK_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .cells_in(cin0),
    .cells_valid(valid0), .cells_ready(ready0), .ena(ena0),
    .x(x0), .cells(cells0), .frame_done(fd0)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  function automatic mdl_t mdlReset();
    mdl_t r;
    r.run = 0; r.t = 0; r.sf = 0; r.sh = '0; r.cells = '0;
    r.loaded = 0; r.ready = 1; r.fd = 0;
    return r;
  endfunction

  // One clock of the model: position inside a frame of 5*(dw+bl) clocks.
  function automatic mdl_t mdlStep(mdl_t c, logic en, logic v, logic [24:0] din, int dw, int bl);
    mdl_t n;
    logic promote;
    logic take;
    int   period;
    n       = c;
    n.fd    = 0;
    promote = 0;
    period  = 5 * (dw + bl);
    take    = v && c.ready;
    if (!c.run) begin
      promote = c.sf;
      if (en && c.loaded) begin
        n.run = 1;
        n.t   = 0;
      end
    end else if (c.t == period - 1) begin
      n.fd    = 1;
      promote = c.sf;
      n.t     = 0;
      n.run   = en;
    end else begin
      n.t = c.t + 1;
    end
    if (promote) begin
      n.cells  = c.sh;
      n.sf     = 0;
      n.loaded = 1;
    end
    if (take) begin
      n.sh = din;
      n.sf = 1;
    end
    n.ready = !n.sf && !promote;
    return n;
  endfunction

  function automatic int expEna(mdl_t c, int dw, int bl);
    return (c.run && ((c.t % (dw + bl)) < dw)) ? 1 : 0;
  endfunction

  function automatic int expX(mdl_t c, int dw, int bl);
    return c.run ? (c.t / (dw + bl)) : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic v, input logic [24:0] d);
    enable      = en;
    cells_valid = v;
    cells_in    = d;
  endtask

  task automatic waitX(input int target);
    int n;
    n = 0;
    while (x !== 3'(target) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("timeout_wait_x", n, 0);
  endtask

  // Model advances on the same edges the DUT sees and resets asynchronously with it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m  <= mdlReset();
      m0 <= mdlReset();
    end else begin
      m  <= mdlStep(m, enable, cells_valid, cells_in, DW, BL);
      m0 <= mdlStep(m0, en0, valid0, cin0, DW, 0);
    end
  end

  // Every falling edge, both instances must match their model.
  always @(negedge clk) begin
    if (cmp_on) begin
      checkOutput("m_ena",   ena,         expEna(m, DW, BL));
      checkOutput("m_x",     x,           expX(m, DW, BL));
      checkOutput("m_cells", cells,       m.cells);
      checkOutput("m_ready", cells_ready, m.ready);
      checkOutput("m_fd",    frame_done,  m.fd);
      checkOutput("m0_ena",   ena0,   expEna(m0, DW, 0));
      checkOutput("m0_x",     x0,     expX(m0, DW, 0));
      checkOutput("m0_cells", cells0, m0.cells);
      checkOutput("m0_ready", ready0, m0.ready);
      checkOutput("m0_fd",    fd0,    m0.fd);
    end
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    int bad;
    int cyc;
    int maxx;
    int fdcnt;
    int fdfirst;
    #1 rst_n = 1'b0;
    cmp_on = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", cells_ready, 1);
    checkOutput("rst_ena", ena, 0);
    checkOutput("rst_x", x, 0);
    checkOutput("rst_cells", cells, 0);
    rst_n = 1'b1;

    // Enabled but nothing loaded: stays dark.
    applyStimulus(1, 0, '0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ena !== 1'b0 || x !== 3'd0 || cells_ready !== 1'b1) bad++;
    end
    checkOutput("idle_no_frame", bad, 0);

    // First frame: load, then scan timing.
    applyStimulus(1, 1, 25'h0000001);
    @(negedge clk);
    applyStimulus(1, 0, '0);
    checkOutput("xfer_ready_low", cells_ready, 0);
    checkOutput("xfer_cells_old", cells, 0);
    @(negedge clk);
    checkOutput("load_cells", cells, 25'h1);
    checkOutput("load_ena", ena, 0);
    @(negedge clk);
    checkOutput("scan_ena_k0", ena, 1);
    checkOutput("scan_x_k0", x, 0);
    repeat (3) @(negedge clk);
    checkOutput("scan_ena_k3", ena, 1);
    @(negedge clk);
    checkOutput("blank_ena_k4", ena, 0);
    @(negedge clk);
    checkOutput("blank_ena_k5", ena, 0);
    checkOutput("blank_x_k5", x, 0);
    @(negedge clk);
    checkOutput("col1_ena_k6", ena, 1);
    checkOutput("col1_x_k6", x, 1);
    cyc = 6;
    while (frame_done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("frame_done_latency", cyc, 30);
    checkOutput("frame2_x", x, 0);
    checkOutput("frame2_ena", ena, 1);

    // Second frame offered mid-scan, third held off, no tearing.
    waitX(2);
    applyStimulus(1, 1, 25'h1FFFFFF);
    @(negedge clk);
    checkOutput("shadow_full_ready", cells_ready, 0);
    checkOutput("shadow_cells_kept", cells, 25'h1);
    applyStimulus(1, 1, 25'h0AAAAAA);
    bad = 0;
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < 100) begin
      if (cells !== 25'h1 || cells_ready !== 1'b0) bad++;
      @(negedge clk);
      cyc++;
    end
    checkOutput("no_tearing", bad, 0);
    checkOutput("promote_cells", cells, 25'h1FFFFFF);
    checkOutput("promote_ready_low", cells_ready, 0);
    @(negedge clk);
    checkOutput("ready_after_promote", cells_ready, 1);
    @(negedge clk);
    applyStimulus(1, 0, '0);
    checkOutput("third_taken_ready", cells_ready, 0);
    checkOutput("third_not_shown", cells, 25'h1FFFFFF);

    // Drop enable mid-frame: frame completes, then idle.
    waitX(2);
    applyStimulus(0, 0, '0);
    maxx = 0;
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < 100) begin
      if (int'(x) > maxx) maxx = int'(x);
      @(negedge clk);
      cyc++;
    end
    checkOutput("full_frame_max_x", maxx, 4);
    checkOutput("stop_x", x, 0);
    checkOutput("stop_ena", ena, 0);
    checkOutput("stop_cells", cells, 25'h0AAAAAA);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (ena !== 1'b0 || x !== 3'd0) bad++;
    end
    checkOutput("idle_after_stop", bad, 0);

    // Async reset mid-scan at column 3.
    applyStimulus(1, 0, '0);
    waitX(3);
    checkOutput("pre_reset_ena", ena, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_ena", ena, 0);
    checkOutput("async_x", x, 0);
    checkOutput("async_cells", cells, 0);
    checkOutput("async_ready", cells_ready, 1);
    checkOutput("async_fd", frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (ena !== 1'b0) bad++;
    end
    checkOutput("no_scan_after_reset", bad, 0);
    applyStimulus(1, 1, 25'h0123456);
    @(negedge clk);
    applyStimulus(1, 0, '0);
    @(negedge clk);
    checkOutput("reload_cells", cells, 25'h0123456);
    @(negedge clk);
    checkOutput("reload_ena", ena, 1);

    // No blanking: continuous ena, x every 4 clocks, frame every 20.
    en0 = 1'b1; valid0 = 1'b1; cin0 = 25'h1555555;
    @(negedge clk);
    valid0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("nb_ena_start", ena0, 1);
    bad = 0;
    fdcnt = 0;
    fdfirst = 0;
    maxx = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (ena0 !== 1'b1) bad++;
      if (x0 !== 3'((k / 4) % 5)) maxx++;
      if (fd0 === 1'b1) begin
        fdcnt++;
        if (fdfirst == 0) fdfirst = k;
      end
    end
    checkOutput("nb_ena_const", bad, 0);
    checkOutput("nb_x_step", maxx, 0);
    checkOutput("nb_fd_count", fdcnt, 3);
    checkOutput("nb_fd_first", fdfirst, 20);

    @(negedge clk);
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/led_array_scanner.md
LED_ARRAY_SCANNER -- requirements
Module: led_array_scanner

Interface
REQ-001 The block SHALL have parameter N, default 5, giving the Conway grid edge length; legal range is 1..8.
REQ-002 The block SHALL have parameter DWELL_CYCLES, default 1000, giving the clocks each column is lit; minimum 1.
REQ-003 The block SHALL have parameter BLANK_CYCLES, default 10, giving the dark clocks between columns; minimum 0.
REQ-004 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low; the single clock and this reset are fixed decisions.
REQ-006 The block SHALL have port enable  input  1  request to scan; sampled at frame boundaries and in IDLE.
REQ-007 The block SHALL have port cells_in  input  N*N  new frame, row-major, bit row*N+col.
REQ-008 The block SHALL have port cells_valid  input  1  cells_in holds a frame offered for transfer.
REQ-009 The block SHALL have port cells_ready  output  1  shadow buffer empty; a transfer occurs on any edge with cells_valid and cells_ready both 1.
REQ-010 The block SHALL have port ena  output  1  column drive enable to the LED array driver.
REQ-011 The block SHALL have port x  output  $clog2(N)+1  current column index to the LED array driver.
REQ-012 The block SHALL have port cells  output  N*N  displayed frame to the LED array driver.
REQ-013 The block SHALL have port frame_done  output  1  one-clock pulse at each completed frame.

Function
REQ-014 The block SHALL hold a one-entry shadow buffer plus a display register; cells SHALL be the display register, and cells_ready SHALL be the registered negation of shadow-full.
REQ-015 The block SHALL implement states IDLE, SCAN and BLANK; ena SHALL be 1 only in SCAN.
REQ-016 In IDLE, a full shadow SHALL be copied to cells on the next edge and the shadow emptied; x SHALL be held at 0.
REQ-017 IDLE SHALL go to SCAN on the first edge where enable=1 and a frame has been loaded since reset.
REQ-018 SCAN SHALL last exactly DWELL_CYCLES clocks per column, then go to BLANK if BLANK_CYCLES>0, otherwise end the column.
REQ-019 BLANK SHALL last exactly BLANK_CYCLES clocks, then end the column.
REQ-020 At a column end with x<N-1, the block SHALL increment x and enter SCAN.
REQ-021 At a column end with x=N-1 (frame boundary), the block SHALL set x to 0, pulse frame_done for one clock, and promote the shadow to cells if full, all on the same edge.
REQ-022 At a frame boundary, the block SHALL enter SCAN if enable=1, otherwise IDLE; deasserting enable mid-frame SHALL NOT truncate the frame.
REQ-023 cells SHALL change only in IDLE or at a frame boundary, never mid-frame (no tearing).
REQ-024 When the shadow is full, cells_ready SHALL be 0 and cells_in SHALL be ignored; after promotion, cells_ready SHALL rise on the following clock.
REQ-025 The frame period SHALL be N*(DWELL_CYCLES+BLANK_CYCLES) clocks; with BLANK_CYCLES=0, ena SHALL stay 1 continuously across columns.
REQ-026 The dwell counter SHALL be wide enough for max(DWELL_CYCLES, BLANK_CYCLES) and SHALL reset to 0 on each state entry.

Reset
REQ-027 On rst_n=0, the block SHALL immediately force IDLE, x=0, ena=0, cells=0, frame_done=0, shadow empty (cells_ready=1), dwell counter=0, and the loaded flag cleared.
REQ-028 Reset asserted mid-frame SHALL discard both shadow and display contents; scanning SHALL resume only after a new transfer.
REQ-029 After rst_n rises, the first active edge SHALL be the first normal clock.

Verification (N=5, DWELL_CYCLES=4, BLANK_CYCLES=2 unless stated)
REQ-030 Reset release, enable=1, no cells_valid -> the bench SHALL show ena=0 and x=0 for 100 clocks, with cells_ready=1.
REQ-031 Transfer of 25'h0000001 with enable=1 -> the bench SHALL show cells=25'h1 one edge later and SCAN the next edge; x SHALL read 0,0,0,0 with ena=1, then 2 clocks with ena=0, then x=1; frame_done SHALL pulse 30 clocks after SCAN entry.
REQ-032 Second frame 25'h1FFFFFF offered at x=2 -> the bench SHALL show it accepted and cells_ready=0; a third frame SHALL be held off; cells SHALL change only on the frame_done edge, and cells_ready SHALL return to 1 one clock later.
REQ-033 enable dropped while x=2 -> the bench SHALL show scanning continue through x=4, then frame_done, then IDLE with x=0 and ena=0.
REQ-034 rst_n pulsed low while x=3 in SCAN -> the bench SHALL show all outputs at reset values asynchronously, and no ena until a new transfer.
REQ-035 BLANK_CYCLES=0 -> the bench SHALL show ena constantly 1, x stepping every 4 clocks, and frame_done every 20 clocks.
